// File: rtl/inst_fetch_buf.sv
// Fetch stage: single-outstanding instruction-memory requests feeding a small PC/instruction FIFO toward decode.
// Optional FETCH_ALIGN_CHK_EN: misaligned PCs become address-error entries instead of memory fetches.
module inst_fetch_buf #(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_ce,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_adv,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_inst,
    input  logic              id_ready,
`ifdef FETCH_ALIGN_CHK_EN
    input  logic              flush,
    output logic              id_exc_adel
`else
    input  logic              flush
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    state_t state, state_nx;

    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] req_pc;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
`ifdef FETCH_ALIGN_CHK_EN
    logic              exc_mem  [DEPTH];
`endif

    logic              pop, push, launch, room, misaligned;
    logic [CNT_W:0]    occupancy;
    logic [ADDR_W-1:0] push_pc;
    logic [DATA_W-1:0] push_inst;
    logic              push_exc;

    assign imem_req = (state != IDLE);
    assign id_valid = (count != '0);
    assign id_pc    = id_valid ? pc_mem[rd_ptr]   : '0;
    assign id_inst  = id_valid ? inst_mem[rd_ptr] : '0;
`ifdef FETCH_ALIGN_CHK_EN
    assign id_exc_adel = id_valid ? exc_mem[rd_ptr] : 1'b0;
    assign misaligned  = (pc[1:0] != 2'b00);
`else
    assign misaligned  = 1'b0;
`endif

    // A word landing from memory this cycle still needs a slot, so WAIT reserves one
    // even on the ack cycle; this is what keeps a back-to-back launch from overflowing.
    always_comb begin
        pop       = id_valid & id_ready & ~flush;
        occupancy = (CNT_W+1)'(count) - (CNT_W+1)'(pop) + (CNT_W+1)'(state == WAIT);
        room      = occupancy < (CNT_W+1)'(DEPTH);
        launch    = pc_ce & ~flush & room &
                    ((state == IDLE) | ((state == WAIT) & imem_ack & ~misaligned));
        pc_adv    = launch;

        state_nx  = state;
        push      = 1'b0;
        push_pc   = req_pc;
        push_inst = imem_rdata;
        push_exc  = 1'b0;

        case (state)
            IDLE: begin
                if (launch) begin
                    if (misaligned) begin
                        push      = 1'b1;
                        push_pc   = pc;
                        push_inst = '0;
                        push_exc  = 1'b1;
                    end else begin
                        state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                if (flush) begin
                    state_nx = imem_ack ? IDLE : DROP;
                end else if (imem_ack) begin
                    push     = 1'b1;
                    state_nx = launch ? WAIT : IDLE;
                end
            end
            DROP: begin
                if (imem_ack) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // The request address is captured once at launch and held until the ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_addr <= '0;
            req_pc    <= '0;
        end else if (launch && !misaligned) begin
`ifdef FETCH_ALIGN_CHK_EN
            imem_addr <= pc;
`else
            imem_addr <= {pc[ADDR_W-1:2], 2'b00};
`endif
            req_pc    <= pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= push_pc;
            inst_mem[wr_ptr] <= push_inst;
`ifdef FETCH_ALIGN_CHK_EN
            exc_mem[wr_ptr]  <= push_exc;
`endif
        end
    end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Self-checking bench for inst_fetch_buf: queue-based fetch model, per-cycle compare, directed scenarios.
// Also covers the FETCH_ALIGN_CHK_EN build when that macro is defined.
module tb_inst_fetch_buf;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pc_ce = 1'b0;
    logic [31:0] pc = 32'h0;
    logic        pc_adv;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready = 1'b0;
    logic        flush = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    logic        id_exc_adel;
`endif

    inst_fetch_buf #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_ce      (pc_ce),
        .pc         (pc),
        .pc_adv     (pc_adv),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_inst    (id_inst),
        .id_ready   (id_ready),
        .flush      (flush)
`ifdef FETCH_ALIGN_CHK_EN
       ,.id_exc_adel(id_exc_adel)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] epc;
        logic [31:0] einst;
        logic        eexc;
    } entry_t;

    entry_t      q[$];
    bit          m_busy, m_drop, m_launched, force_ack;
    logic [31:0] m_addr;
    int          wcnt, lat;
    int          n_cmp, n_err;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {16'hDEAD, a[15:0]};
    endfunction

    function automatic logic [31:0] align4(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    function automatic bit misal(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHK_EN
        return a[1:0] != 2'b00;
`else
        return 1'b0;
`endif
    endfunction

    // Fetch may start when nothing is outstanding (or it completes now) and the FIFO,
    // counting the word landing this cycle, still has a free slot afterwards.
    function automatic bit exp_launch();
        bit pop;
        int occ;
        pop = (q.size() != 0) && id_ready;
        occ = q.size() - int'(pop) + ((m_busy && !m_drop) ? 1 : 0);
        return pc_ce && !flush && !m_drop && (!m_busy || imem_ack) && (occ < DEPTH)
               && !(m_busy && misal(pc));
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_drop = 0; m_launched = 0; m_addr = 32'h0; wcnt = 0;
    endtask

    task automatic model_step();
        bit ack, pop, launch, newreq;
        if (rst) begin
            model_reset();
            return;
        end
        ack    = imem_ack && m_busy;
        pop    = (q.size() != 0) && id_ready && !flush;
        launch = exp_launch();
        newreq = 0;
        if (flush) begin
            q.delete();
            if (m_busy) begin
                if (ack) begin m_busy = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else begin
            if (pop) void'(q.pop_front());
            if (ack && !m_drop) q.push_back('{epc: m_addr, einst: memf(align4(m_addr)), eexc: 1'b0});
            if (ack) begin m_busy = 0; m_drop = 0; end
            if (launch) begin
                if (misal(pc)) q.push_back('{epc: pc, einst: 32'h0, eexc: 1'b1});
                else begin m_busy = 1; m_addr = pc; newreq = 1; end
            end
        end
        m_launched = launch;
        if (newreq) wcnt = 0;
        else if (m_busy) wcnt++;
    endtask

    task automatic drive_mem();
        imem_ack   = force_ack || (m_busy && (wcnt >= lat - 1));
        imem_rdata = imem_ack ? memf(imem_addr) : 32'h0;
    endtask

    // One clock: update the model at the edge, then let the PC stage and memory respond.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        if (m_launched) pc = pc + 32'd4;
        drive_mem();
    endtask

    task automatic applyStimulus(input bit ce, input bit rdy, input bit fl);
        pc_ce = ce; id_ready = rdy; flush = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                checkOutput("cmp id_valid", 32'(id_valid), 32'd1);
                checkOutput("cmp id_pc", id_pc, q[0].epc);
                checkOutput("cmp id_inst", id_inst, q[0].einst);
`ifdef FETCH_ALIGN_CHK_EN
                checkOutput("cmp id_exc_adel", 32'(id_exc_adel), 32'(q[0].eexc));
`endif
            end else begin
                checkOutput("cmp id_valid", 32'(id_valid), 32'd0);
                checkOutput("cmp id_pc", id_pc, 32'h0);
                checkOutput("cmp id_inst", id_inst, 32'h0);
`ifdef FETCH_ALIGN_CHK_EN
                checkOutput("cmp id_exc_adel", 32'(id_exc_adel), 32'd0);
`endif
            end
            checkOutput("cmp imem_req", 32'(imem_req), 32'(m_busy));
            if (m_busy) checkOutput("cmp imem_addr", imem_addr, align4(m_addr));
            checkOutput("cmp pc_adv", 32'(pc_adv), 32'(exp_launch()));
        end
    end

    initial begin
        model_reset();
        lat = 1; force_ack = 0; n_cmp = 0; n_err = 0;
        repeat (2) tick();
        @(negedge clk);
        checkOutput("rst imem_req", 32'(imem_req), 32'd0);
        checkOutput("rst imem_addr", imem_addr, 32'h0);
        checkOutput("rst id_valid", 32'(id_valid), 32'd0);
        checkOutput("rst id_pc", id_pc, 32'h0);
        checkOutput("rst id_inst", id_inst, 32'h0);
        checkOutput("rst pc_adv", 32'(pc_adv), 32'd0);
        tick(); rst = 0;

        // Zero-wait streaming from 0x0
        tick(); applyStimulus(1, 1, 0); pc = 32'h0;
        @(negedge clk); checkOutput("t1 pc_adv c0", 32'(pc_adv), 32'd1);
        checkOutput("t1 imem_req c0", 32'(imem_req), 32'd0);
        tick(); @(negedge clk); checkOutput("t1 imem_req c1", 32'(imem_req), 32'd1);
        checkOutput("t1 imem_addr c1", imem_addr, 32'h0);
        tick(); @(negedge clk); checkOutput("t1 id_valid c2", 32'(id_valid), 32'd1);
        checkOutput("t1 id_pc c2", id_pc, 32'h0);
        checkOutput("t1 id_inst c2", id_inst, 32'hDEAD_0000);
        tick(); @(negedge clk); checkOutput("t1 id_pc c3", id_pc, 32'h4);
        checkOutput("t1 id_inst c3", id_inst, 32'hDEAD_0004);
        tick(); @(negedge clk); checkOutput("t1 id_pc c4", id_pc, 32'h8);
        tick(); applyStimulus(0, 1, 0);
        @(negedge clk); checkOutput("t1 id_pc c5", id_pc, 32'hC);
        checkOutput("t1 id_inst c5", id_inst, 32'hDEAD_000C);
        repeat (4) tick();

        // Three-cycle memory latency at 0x100
        lat = 3;
        tick(); applyStimulus(1, 1, 0); pc = 32'h100;
        @(negedge clk); checkOutput("t2 pc_adv launch", 32'(pc_adv), 32'd1);
        tick(); applyStimulus(0, 1, 0);
        @(negedge clk); checkOutput("t2 imem_req c1", 32'(imem_req), 32'd1);
        checkOutput("t2 imem_addr c1", imem_addr, 32'h100);
        checkOutput("t2 pc_adv c1", 32'(pc_adv), 32'd0);
        tick(); @(negedge clk); checkOutput("t2 imem_addr c2", imem_addr, 32'h100);
        tick(); @(negedge clk); checkOutput("t2 imem_req c3", 32'(imem_req), 32'd1);
        checkOutput("t2 id_valid c3", 32'(id_valid), 32'd0);
        tick(); @(negedge clk); checkOutput("t2 imem_req c4", 32'(imem_req), 32'd0);
        checkOutput("t2 id_pc c4", id_pc, 32'h100);
        checkOutput("t2 id_inst c4", id_inst, 32'hDEAD_0100);
        repeat (2) tick();

        // Decode stalled: FIFO fills to DEPTH, then drains in order
        lat = 1;
        tick(); applyStimulus(1, 0, 0); pc = 32'h0;
        repeat (3) tick();
        @(negedge clk); checkOutput("t3 full id_pc", id_pc, 32'h0);
        checkOutput("t3 full pc_adv", 32'(pc_adv), 32'd0);
        checkOutput("t3 full imem_req", 32'(imem_req), 32'd0);
        tick(); @(negedge clk); checkOutput("t3 hold imem_req", 32'(imem_req), 32'd0);
        tick(); applyStimulus(1, 1, 0);
        @(negedge clk); checkOutput("t3 drain id_pc0", id_pc, 32'h0);
        checkOutput("t3 resume pc_adv", 32'(pc_adv), 32'd1);
        tick(); @(negedge clk); checkOutput("t3 drain id_pc1", id_pc, 32'h4);
        checkOutput("t3 resume imem_addr", imem_addr, 32'h8);
        tick(); @(negedge clk); checkOutput("t3 drain id_pc2", id_pc, 32'h8);
        checkOutput("t3 drain id_inst2", id_inst, 32'hDEAD_0008);
        tick(); applyStimulus(0, 1, 0);
        repeat (4) tick();

        // Flush while waiting on 0x20, then redirect to 0x80
        lat = 3;
        tick(); applyStimulus(1, 1, 0); pc = 32'h20;
        tick(); applyStimulus(0, 1, 1);
        @(negedge clk); checkOutput("t4 imem_addr", imem_addr, 32'h20);
        checkOutput("t4 flush pc_adv", 32'(pc_adv), 32'd0);
        tick(); applyStimulus(0, 1, 0);
        @(negedge clk); checkOutput("t4 drop imem_req", 32'(imem_req), 32'd1);
        tick(); @(negedge clk); checkOutput("t4 late ack id_valid", 32'(id_valid), 32'd0);
        tick(); lat = 1; pc = 32'h80; applyStimulus(1, 1, 0);
        @(negedge clk); checkOutput("t4 after drop id_valid", 32'(id_valid), 32'd0);
        checkOutput("t4 redirect pc_adv", 32'(pc_adv), 32'd1);
        tick(); applyStimulus(0, 1, 0);
        tick(); @(negedge clk); checkOutput("t4 redirect id_pc", id_pc, 32'h80);
        checkOutput("t4 redirect id_inst", id_inst, 32'hDEAD_0080);
        repeat (2) tick();

        // Flush with a buffered entry and an ack in the same cycle
        tick(); applyStimulus(1, 0, 0); pc = 32'h40;
        tick();
        tick(); applyStimulus(0, 0, 1);
        @(negedge clk); checkOutput("t4b pre id_pc", id_pc, 32'h40);
        tick(); applyStimulus(0, 1, 0);
        @(negedge clk); checkOutput("t4b id_valid", 32'(id_valid), 32'd0);
        checkOutput("t4b imem_req", 32'(imem_req), 32'd0);
        repeat (2) tick();

        // Reset while waiting, stray ack right after release
        lat = 3;
        tick(); applyStimulus(1, 1, 0); pc = 32'h200;
        tick(); applyStimulus(0, 1, 0);
        rst = 1; model_reset(); drive_mem();
        @(negedge clk); checkOutput("t5 rst imem_req", 32'(imem_req), 32'd0);
        checkOutput("t5 rst imem_addr", imem_addr, 32'h0);
        checkOutput("t5 rst id_valid", 32'(id_valid), 32'd0);
        tick(); rst = 0; force_ack = 1;
        tick(); force_ack = 0;
        @(negedge clk); checkOutput("t5 stray ack imem_req", 32'(imem_req), 32'd0);
        tick(); @(negedge clk); checkOutput("t5 stray ack id_valid", 32'(id_valid), 32'd0);
        checkOutput("t5 stray ack id_pc", id_pc, 32'h0);
        repeat (2) tick();

        lat = 1;
`ifdef FETCH_ALIGN_CHK_EN
        // Misaligned PC becomes an address-error entry, no memory request
        tick(); applyStimulus(1, 1, 0); pc = 32'h6;
        @(negedge clk); checkOutput("t6 adel pc_adv", 32'(pc_adv), 32'd1);
        tick(); applyStimulus(0, 1, 0);
        @(negedge clk); checkOutput("t6 adel imem_req", 32'(imem_req), 32'd0);
        checkOutput("t6 adel id_valid", 32'(id_valid), 32'd1);
        checkOutput("t6 adel id_pc", id_pc, 32'h6);
        checkOutput("t6 adel id_inst", id_inst, 32'h0);
        checkOutput("t6 adel exc", 32'(id_exc_adel), 32'd1);
`else
        // Low PC bits never reach memory but stay visible to decode
        tick(); applyStimulus(1, 1, 0); pc = 32'h103;
        tick(); applyStimulus(0, 1, 0);
        @(negedge clk); checkOutput("t6 imem_addr aligned", imem_addr, 32'h100);
        tick(); @(negedge clk); checkOutput("t6 id_pc raw", id_pc, 32'h103);
        checkOutput("t6 id_inst", id_inst, 32'hDEAD_0100);
`endif
        repeat (3) tick();
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
